// File: rtl/vec_result_collector.sv
// Result collector for the 8-lane vector add PE: tracks issued ops through a
// latency-matched valid/tag pipeline, buffers lane results and drains them lane by lane.
module vec_result_collector #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             issue_ready,
    input  logic [31:0]      in0,
    input  logic [31:0]      in1,
    input  logic [31:0]      in2,
    input  logic [31:0]      in3,
    input  logic [31:0]      in4,
    input  logic [31:0]      in5,
    input  logic [31:0]      in6,
    input  logic [31:0]      in7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [2:0]       out_lane,
    output logic             out_last,
    output logic [TAG_W-1:0] out_tag,
    output logic             err_drop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = $clog2(DEPTH + LATENCY + 1) + 1;

    typedef enum logic {IDLE, SEND} state_e;

    state_e             state_q, state_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [TAG_W-1:0]   ptag_q [LATENCY];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2:0]         lane_q, lane_d;
    logic               err_drop_q, err_drop_d;

    logic [31:0]        bdata_q [DEPTH][8];
    logic [TAG_W-1:0]   btag_q  [DEPTH];
    logic [31:0]        lane_in [8];

    logic               ready;
    logic               accept;
    logic               capture;
    logic               pop_vec;
    logic [SUM_W-1:0]   inflight;

    always_comb begin
        lane_in[0] = in0;
        lane_in[1] = in1;
        lane_in[2] = in2;
        lane_in[3] = in3;
        lane_in[4] = in4;
        lane_in[5] = in5;
        lane_in[6] = in6;
        lane_in[7] = in7;
    end

    // Credits come from registered state only, so issue_ready never depends on issue_valid.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + SUM_W'(vld_q[i]);
        end
        ready = (SUM_W'(count_q) + inflight) < SUM_W'(DEPTH);
    end

    assign issue_ready = ready;
    assign accept      = issue_valid && ready;
    assign capture     = vld_q[LATENCY-1];
    assign pop_vec     = (state_q == SEND) && out_ready && (lane_q == 3'd7);
    assign err_drop    = err_drop_q;

    always_comb begin
        vld_d[0] = accept;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        ptag_q[0] <= issue_tag;
        for (int i = 1; i < LATENCY; i++) begin
            ptag_q[i] <= ptag_q[i-1];
        end
    end

    // The buffer is never full at capture time thanks to the credit check above.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int l = 0; l < 8; l++) begin
                bdata_q[wr_ptr_q][l] <= lane_in[l];
            end
            btag_q[wr_ptr_q] <= ptag_q[LATENCY-1];
        end
    end

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = capture ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d    = count_q + CNT_W'(capture) - CNT_W'(pop_vec);
        err_drop_d = err_drop_q | (issue_valid & ~ready);
        out_valid  = 1'b0;
        out_data   = '0;
        out_lane   = '0;
        out_last   = 1'b0;
        out_tag    = '0;
        unique case (state_q)
            IDLE: begin
                // Entering SEND on the capture edge avoids a fall-through bubble.
                if (count_q != '0 || capture) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = bdata_q[rd_ptr_q][lane_q];
                out_lane  = lane_q;
                out_last  = (lane_q == 3'd7);
                out_tag   = btag_q[rd_ptr_q];
                if (out_ready) begin
                    if (lane_q == 3'd7) begin
                        lane_d   = 3'd0;
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        if (count_d == '0) begin
                            state_d = IDLE;
                        end
                    end else begin
                        lane_d = lane_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lane_q     <= '0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lane_q     <= lane_d;
            err_drop_q <= err_drop_d;
        end
    end

endmodule

// File: tb/tb_vec_result_collector.sv
// Directed bench for vec_result_collector: three instances (LATENCY 4, 1, 16) share stimulus.
module tb_vec_result_collector;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [3:0]  issue_tag;
    logic        out_ready;
    logic [31:0] din [8];

    logic        o4_ready, o4_valid, o4_last, o4_err;
    logic [31:0] o4_data;
    logic [2:0]  o4_lane;
    logic [3:0]  o4_tag;
    logic        o1_ready, o1_valid, o1_last, o1_err;
    logic [31:0] o1_data;
    logic [2:0]  o1_lane;
    logic [3:0]  o1_tag;
    logic        o16_ready, o16_valid, o16_last, o16_err;
    logic [31:0] o16_data;
    logic [2:0]  o16_lane;
    logic [3:0]  o16_tag;

    int n_err = 0;
    int n_chk = 0;
    int ecnt  = 0;

    vec_result_collector #(.LATENCY(4), .DEPTH(4), .TAG_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_tag(issue_tag),
        .issue_ready(o4_ready), .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]), .out_valid(o4_valid),
        .out_ready(out_ready), .out_data(o4_data), .out_lane(o4_lane), .out_last(o4_last),
        .out_tag(o4_tag), .err_drop(o4_err));

    vec_result_collector #(.LATENCY(1), .DEPTH(4), .TAG_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_tag(issue_tag),
        .issue_ready(o1_ready), .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]), .out_valid(o1_valid),
        .out_ready(out_ready), .out_data(o1_data), .out_lane(o1_lane), .out_last(o1_last),
        .out_tag(o1_tag), .err_drop(o1_err));

    vec_result_collector #(.LATENCY(16), .DEPTH(4), .TAG_W(4)) u16 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_tag(issue_tag),
        .issue_ready(o16_ready), .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]), .out_valid(o16_valid),
        .out_ready(out_ready), .out_data(o16_data), .out_lane(o16_lane), .out_last(o16_last),
        .out_tag(o16_tag), .err_drop(o16_err));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic set_in(input logic [31:0] base);
        for (int l = 0; l < 8; l++) din[l] = base + 32'(l);
    endtask

    function automatic logic [31:0] pat(input int e);
        return 32'h4000_0000 + 32'(e) * 32'd256;
    endfunction

    task automatic chk_idle(input string name);
        check({name, "_valid"}, 32'(o4_valid), 32'd0);
        check({name, "_data"},  o4_data,        32'd0);
        check({name, "_lane"},  32'(o4_lane),  32'd0);
        check({name, "_last"},  32'(o4_last),  32'd0);
        check({name, "_tag"},   32'(o4_tag),   32'd0);
        check({name, "_err"},   32'(o4_err),   32'd0);
        check({name, "_ready"}, 32'(o4_ready), 32'd1);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        out_ready   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic rdy_pat [4];
    int   iss_edge [10];

    initial begin
        int s;
        int exp_lane;
        int n_iss;
        int n_beats;
        int nxt;
        int v;
        int l;
        bit started;

        rdy_pat     = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst_n       = 1'b1;
        issue_valid = 1'b0;
        issue_tag   = '0;
        out_ready   = 1'b0;
        set_in(32'd0);
        #1 rst_n = 1'b0;
        #2 chk_idle("reset");
        step();
        step();
        rst_n = 1'b1;

        // Single vector, LATENCY 4
        issue_valid = 1'b1;
        issue_tag   = 4'h3;
        set_in(32'hDEAD_0000);
        step();
        issue_valid = 1'b0;
        out_ready   = 1'b1;
        step();
        step();
        step();
        check("t1_pre_valid", 32'(o4_valid), 32'd0);
        set_in(32'h3F80_0000);
        step();
        set_in(32'hDEAD_0000);
        for (int i = 0; i < 8; i++) begin
            check("t1_valid", 32'(o4_valid), 32'd1);
            check("t1_lane",  32'(o4_lane),  32'(i));
            check("t1_data",  o4_data,        32'h3F80_0000 + 32'(i));
            check("t1_tag",   32'(o4_tag),   32'h3);
            check("t1_last",  32'(o4_last),  32'(i == 7));
            step();
        end
        check("t1_post_valid", 32'(o4_valid), 32'd0);

        // Credit limit
        out_ready = 1'b0;
        set_in(32'h2000_0000);
        for (int i = 0; i < 6; i++) begin
            issue_valid = 1'b1;
            issue_tag   = 4'(i + 1);
            check("t2_issue_ready", 32'(o4_ready), 32'(i < 4));
            step();
        end
        issue_valid = 1'b0;
        check("t2_err_drop", 32'(o4_err), 32'd1);
        step();
        step();
        step();
        check("t2_full_ready", 32'(o4_ready), 32'd0);
        check("t2_stall_valid", 32'(o4_valid), 32'd1);
        check("t2_stall_tag", 32'(o4_tag), 32'd1);
        out_ready = 1'b1;
        for (int vv = 0; vv < 4; vv++) begin
            for (int i = 0; i < 8; i++) begin
                check("t2_valid", 32'(o4_valid), 32'd1);
                check("t2_lane",  32'(o4_lane),  32'(i));
                check("t2_tag",   32'(o4_tag),   32'(vv + 1));
                check("t2_data",  o4_data,        32'h2000_0000 + 32'(i));
                check("t2_last",  32'(o4_last),  32'(i == 7));
                step();
            end
        end
        check("t2_drained", 32'(o4_valid), 32'd0);
        check("t2_ready_back", 32'(o4_ready), 32'd1);
        check("t2_err_sticky", 32'(o4_err), 32'd1);

        // Backpressure
        do_reset();
        check("t3_err_cleared", 32'(o4_err), 32'd0);
        set_in(32'h3000_0000);
        issue_valid = 1'b1;
        issue_tag   = 4'h7;
        step();
        issue_valid = 1'b0;
        step();
        step();
        step();
        step();
        exp_lane = 0;
        for (int c = 0; c < 40 && exp_lane < 8; c++) begin
            out_ready = rdy_pat[c % 4];
            check("t3_valid", 32'(o4_valid), 32'd1);
            check("t3_lane",  32'(o4_lane),  32'(exp_lane));
            check("t3_data",  o4_data,        32'h3000_0000 + 32'(exp_lane));
            check("t3_tag",   32'(o4_tag),   32'h7);
            check("t3_last",  32'(o4_last),  32'(exp_lane == 7));
            step();
            if (out_ready) exp_lane++;
        end
        check("t3_all_beats", 32'(exp_lane), 32'd8);
        check("t3_post_valid", 32'(o4_valid), 32'd0);

        // Wrap with capture coinciding with final-beat pops
        out_ready = 1'b1;
        n_iss     = 0;
        n_beats   = 0;
        started   = 1'b0;
        s         = ecnt + 1;
        for (int c = 0; c < 200 && n_beats < 80; c++) begin
            if (started || o4_valid) begin
                started = 1'b1;
                v = n_beats / 8;
                l = n_beats % 8;
                check("t4_valid", 32'(o4_valid), 32'd1);
                check("t4_lane",  32'(o4_lane),  32'(l));
                check("t4_tag",   32'(o4_tag),   32'((v + 1) % 16));
                check("t4_data",  o4_data,        pat(iss_edge[v] + 4) + 32'(l));
                check("t4_last",  32'(o4_last),  32'(l == 7));
                n_beats++;
            end
            nxt = ecnt + 1;
            if (n_iss < 10 && ((nxt - s) % 8) == 0) begin
                issue_valid = 1'b1;
                issue_tag   = 4'(n_iss + 1);
                check("t4_issue_ready", 32'(o4_ready), 32'd1);
                iss_edge[n_iss] = nxt;
                n_iss++;
            end else begin
                issue_valid = 1'b0;
            end
            set_in(pat(nxt));
            step();
        end
        issue_valid = 1'b0;
        check("t4_all_beats", 32'(n_beats), 32'd80);
        check("t4_post_valid", 32'(o4_valid), 32'd0);
        check("t4_no_drop", 32'(o4_err), 32'd0);

        // Reset mid-drain with two operations in flight
        do_reset();
        out_ready = 1'b1;
        set_in(32'h5000_0000);
        issue_valid = 1'b1;
        issue_tag   = 4'h1;
        step();
        issue_tag   = 4'h2;
        step();
        issue_valid = 1'b0;
        step();
        step();
        step();
        issue_valid = 1'b1;
        issue_tag   = 4'h3;
        step();
        issue_tag   = 4'h4;
        step();
        issue_valid = 1'b0;
        step();
        check("t5_lane3", 32'(o4_lane), 32'd3);
        check("t5_tag1",  32'(o4_tag),  32'd1);
        #2 rst_n = 1'b0;
        #1 chk_idle("t5_reset");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t5_late_valid", 32'(o4_valid), 32'd0);
            check("t5_late_ready", 32'(o4_ready), 32'd1);
        end

        // Latency sweep: each instance captures exactly LATENCY edges after issue
        do_reset();
        out_ready   = 1'b0;
        issue_valid = 1'b1;
        issue_tag   = 4'h9;
        s           = ecnt + 1;
        set_in(pat(s));
        step();
        issue_valid = 1'b0;
        for (int t = 1; t <= 18; t++) begin
            set_in(pat(ecnt + 1));
            step();
            check("t6_l1_valid",  32'(o1_valid),  32'(t >= 1));
            check("t6_l4_valid",  32'(o4_valid),  32'(t >= 4));
            check("t6_l16_valid", 32'(o16_valid), 32'(t >= 16));
        end
        check("t6_l1_data",  o1_data,  pat(s + 1));
        check("t6_l4_data",  o4_data,  pat(s + 4));
        check("t6_l16_data", o16_data, pat(s + 16));
        check("t6_l1_tag",   32'(o1_tag),  32'h9);
        check("t6_l16_tag",  32'(o16_tag), 32'h9);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
